i2c_target_regfile: RTL

//  I2C target (responder) for the I2C controller in the mmio subsystem: 7-bit address, 8-bit register file,

---
 rtl/i2c_pkg.sv | 22 ++
 rtl/i2c_line_filter.sv | 36 +++
 rtl/i2c_target_regfile.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned BIT_CNT_W = 4;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      PTR,
      PTR_ACK,
      WDATA,
      WDATA_ACK,
      RDATA,
      RDATA_ACK
   } state_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer followed by a stability filter for one open-drain bus line.
// The filtered level only follows the line once it has held a new value for FILT_LEN cycles.
module i2c_line_filter #(
   parameter int unsigned FILT_LEN = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic line,
   output logic level
);

   localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic [1:0]       sync;
   logic [CNT_W-1:0] cnt;

   // Idle bus level is high, so the filter wakes up released.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync  <= 2'b11;
         cnt   <= '0;
         level <= 1'b1;
      end else begin
         sync <= {sync[0], line};
         if (sync[1] == level) begin
            cnt <= '0;
         end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
            level <= sync[1];
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an auto-incrementing register pointer and an 8-bit register file.
// A local port reads the register file combinationally and reports every bus write.
module i2c_target_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0]   DEV_ADDR = 7'h48,
   parameter int unsigned  N_REG    = 8,
   parameter int unsigned  FILT_LEN = 3,
   localparam int unsigned PW       = $clog2(N_REG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   input  logic [PW-1:0]     rd_addr,
   output logic [BYTE_W-1:0] rd_data,
   output logic              wr_stb,
   output logic [PW-1:0]     wr_addr,
   output logic [BYTE_W-1:0] wr_data,
   output logic              busy
);

   logic                 scl_f, sda_f, scl_q, sda_q;
   logic                 scl_rise_c, scl_fall_c, start_c, stop_c, byte_done_c;
   state_t               state, state_n;
   logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_n;
   logic [BYTE_W-1:0]    shift, shift_n, shift_in_c;
   logic [PW-1:0]        ptr, ptr_n, ptr_inc_c;
   logic                 sda_oe_n, busy_n, wr_stb_n, reg_we_c;
   logic [PW-1:0]        wr_addr_n;
   logic [BYTE_W-1:0]    wr_data_n;
   logic [BYTE_W-1:0]    regs [N_REG];

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk   (clk),
      .reset (reset),
      .line  (scl_in),
      .level (scl_f)
   );

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk   (clk),
      .reset (reset),
      .line  (sda_in),
      .level (sda_f)
   );

   // Previous filtered levels for edge and START/STOP detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_f;
         sda_q <= sda_f;
      end
   end

   assign scl_rise_c  = scl_f & ~scl_q;
   assign scl_fall_c  = ~scl_f & scl_q;
   assign start_c     = scl_f & scl_q & sda_q & ~sda_f;
   assign stop_c      = scl_f & scl_q & ~sda_q & sda_f;
   assign byte_done_c = (bit_cnt == BIT_CNT_W'(BYTE_W));
   assign shift_in_c  = {shift[BYTE_W-2:0], sda_f};
   assign ptr_inc_c   = ptr + PW'(1);
   assign rd_data     = regs[rd_addr];

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Bits are sampled on SCL rise; SDA is only moved after an SCL fall.
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shift_n   = shift;
      ptr_n     = ptr;
      sda_oe_n  = sda_oe;
      busy_n    = busy;
      wr_stb_n  = 1'b0;
      wr_addr_n = wr_addr;
      wr_data_n = wr_data;
      reg_we_c  = 1'b0;

      if (start_c) begin
         state_n   = ADDR;
         bit_cnt_n = '0;
         sda_oe_n  = 1'b0;
      end else if (stop_c) begin
         state_n   = IDLE;
         bit_cnt_n = '0;
         sda_oe_n  = 1'b0;
         busy_n    = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bit_cnt_n = '0;
            end
            ADDR: begin
               if (scl_rise_c) begin
                  shift_n   = shift_in_c;
                  bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
               end else if (scl_fall_c && byte_done_c) begin
                  bit_cnt_n = '0;
                  if (shift[BYTE_W-1:1] == DEV_ADDR) begin
                     state_n  = ADDR_ACK;
                     sda_oe_n = 1'b1;
                     busy_n   = 1'b1;
                  end else begin
                     state_n = IDLE;
                     busy_n  = 1'b0;
                  end
               end
            end
            ADDR_ACK: begin
               // shift[0] still holds the R/W bit of the address byte.
               if (scl_fall_c) begin
                  if (shift[0]) begin
                     state_n  = RDATA;
                     shift_n  = regs[ptr];
                     sda_oe_n = ~regs[ptr][BYTE_W-1];
                  end else begin
                     state_n  = PTR;
                     sda_oe_n = 1'b0;
                  end
               end
            end
            PTR: begin
               if (scl_rise_c) begin
                  shift_n   = shift_in_c;
                  bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
               end else if (scl_fall_c && byte_done_c) begin
                  bit_cnt_n = '0;
                  ptr_n     = PW'(shift);
                  sda_oe_n  = 1'b1;
                  state_n   = PTR_ACK;
               end
            end
            PTR_ACK: begin
               if (scl_fall_c) begin
                  sda_oe_n = 1'b0;
                  state_n  = WDATA;
               end
            end
            WDATA: begin
               if (scl_rise_c) begin
                  shift_n   = shift_in_c;
                  bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
               end else if (scl_fall_c && byte_done_c) begin
                  bit_cnt_n = '0;
                  reg_we_c  = 1'b1;
                  wr_stb_n  = 1'b1;
                  wr_addr_n = ptr;
                  wr_data_n = shift;
                  sda_oe_n  = 1'b1;
                  state_n   = WDATA_ACK;
               end
            end
            WDATA_ACK: begin
               if (scl_fall_c) begin
                  sda_oe_n = 1'b0;
                  ptr_n    = ptr_inc_c;
                  state_n  = WDATA;
               end
            end
            RDATA: begin
               if (scl_rise_c) begin
                  bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
               end else if (scl_fall_c) begin
                  if (byte_done_c) begin
                     bit_cnt_n = '0;
                     sda_oe_n  = 1'b0;
                     state_n   = RDATA_ACK;
                  end else begin
                     shift_n  = {shift[BYTE_W-2:0], 1'b0};
                     sda_oe_n = ~shift[BYTE_W-2];
                  end
               end
            end
            RDATA_ACK: begin
               // A NACK ends the read at the ack rise; an ACK reloads on the following fall.
               if (scl_rise_c && (sda_f == I2C_NACK)) begin
                  ptr_n   = ptr_inc_c;
                  busy_n  = 1'b0;
                  state_n = IDLE;
               end else if (scl_fall_c) begin
                  ptr_n    = ptr_inc_c;
                  shift_n  = regs[ptr_inc_c];
                  sda_oe_n = ~regs[ptr_inc_c][BYTE_W-1];
                  state_n  = RDATA;
               end
            end
            default: begin
               state_n  = IDLE;
               sda_oe_n = 1'b0;
               busy_n   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_cnt <= '0;
         shift   <= '0;
         ptr     <= '0;
         sda_oe  <= 1'b0;
         busy    <= 1'b0;
         wr_stb  <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
      end else begin
         bit_cnt <= bit_cnt_n;
         shift   <= shift_n;
         ptr     <= ptr_n;
         sda_oe  <= sda_oe_n;
         busy    <= busy_n;
         wr_stb  <= wr_stb_n;
         wr_addr <= wr_addr_n;
         wr_data <= wr_data_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)         regs      <= '{default: '0};
      else if (reg_we_c) regs[ptr] <= shift;
   end

endmodule
